block_header_stream: RTL and testbench

BLOCK_HEADER_STREAM -- requirements
Module: block_header_stream

---
 rtl/block_header_stream_pkg.sv | 24 ++
 rtl/block_header_stream_delta_width.sv | 23 ++
 rtl/block_header_stream.sv | 150 +++++++++++++++
 tb/tb_block_header_stream.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/block_header_stream_pkg.sv
// Shared constants and types for the block header stream.
package block_header_stream_pkg;

    localparam int DEF_NUM_PIX      = 32;
    localparam int DEF_PIX_PER_BEAT = 4;
    localparam int DEF_NUM_CH       = 4;
    localparam int DEF_CH_W         = 8;
    localparam int DEF_MAX_DW       = 4;
    localparam int DEF_DW_W         = $clog2(DEF_CH_W + 1);

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        CALC  = 2'd1,
        OUT   = 2'd2
    } state_t;

    // One header field at default widths; packing order matches the h layout.
    typedef struct packed {
        logic                skip;
        logic [DEF_DW_W-1:0] dw;
        logic [DEF_CH_W-1:0] min;
    } hdr_fld_t;

endpackage

// File: rtl/block_header_stream_delta_width.sv
// Maps an unsigned channel range (max - min) to the bit width needed to
// encode deltas: 0 for an empty range, otherwise index of the top set bit + 1.
module delta_width
    import block_header_stream_pkg::*;
#(
    parameter int CH_W = DEF_CH_W,
    parameter int DW_W = $clog2(CH_W + 1)
) (
    input  logic [CH_W-1:0] span,
    output logic [DW_W-1:0] dw
);

    // Highest set bit wins because later iterations overwrite earlier ones.
    always_comb begin
        dw = '0;
        for (int i = 0; i < CH_W; i++) begin
            if (span[i]) begin
                dw = DW_W'(i + 1);
            end
        end
    end

endmodule

// File: rtl/block_header_stream.sv
// Accumulates per-channel min/max over a block of pixels arriving in beats,
// then emits a header (min, delta width, skip flag per channel) and a flag
// telling whether every channel fits within MAX_DW delta bits.
module block_header_stream
    import block_header_stream_pkg::*;
#(
    parameter int NUM_PIX      = DEF_NUM_PIX,
    parameter int PIX_PER_BEAT = DEF_PIX_PER_BEAT,
    parameter int NUM_CH       = DEF_NUM_CH,
    parameter int CH_W         = DEF_CH_W,
    parameter int MAX_DW       = DEF_MAX_DW,
    localparam int DW_W        = $clog2(CH_W + 1),
    localparam int FLD_W       = CH_W + DW_W + 1,
    localparam int HDR_W       = NUM_CH * FLD_W
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    input  logic [PIX_PER_BEAT-1:0][NUM_CH-1:0][CH_W-1:0] in_pix,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic [HDR_W-1:0]                           h,
    output logic                                       compressable
);

    localparam int BEATS = NUM_PIX / PIX_PER_BEAT;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    state_t state, state_next;
    logic [CNT_W-1:0] beat_cnt;
    logic [NUM_CH-1:0][CH_W-1:0] min_r, max_r, min_beat, max_beat, span;
    logic [NUM_CH-1:0][DW_W-1:0] dw;
    logic [HDR_W-1:0] h_next;
    logic comp_next;
    logic xfer;

    assign xfer = in_valid && in_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && (beat_cnt == LAST_BEAT)) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                state_next = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = ACCUM;
                end
            end
            default: begin
                state_next = ACCUM;
            end
        endcase
    end

    // Fold every pixel of the current beat into the running min/max.
    always_comb begin
        min_beat = min_r;
        max_beat = max_r;
        for (int p = 0; p < PIX_PER_BEAT; p++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (in_pix[p][c] < min_beat[c]) begin
                    min_beat[c] = in_pix[p][c];
                end
                if (in_pix[p][c] > max_beat[c]) begin
                    max_beat[c] = in_pix[p][c];
                end
            end
        end
    end

    // Range is only consumed in CALC, where at least one beat has made max >= min.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign span[c] = max_r[c] - min_r[c];
        delta_width #(
            .CH_W (CH_W),
            .DW_W (DW_W)
        ) u_delta_width (
            .span (span[c]),
            .dw   (dw[c])
        );
    end

    // Assemble the header fields and the compressable flag.
    always_comb begin
        h_next    = '0;
        comp_next = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            h_next[c*FLD_W +: FLD_W] = {(max_r[c] == min_r[c]), dw[c], min_r[c]};
            if (dw[c] > DW_W'(MAX_DW)) begin
                comp_next = 1'b0;
            end
        end
    end

    // Running statistics, beat counter and registered header.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt     <= '0;
            min_r        <= '1;
            max_r        <= '0;
            h            <= '0;
            compressable <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (xfer) begin
                        min_r    <= min_beat;
                        max_r    <= max_beat;
                        beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + CNT_W'(1);
                    end
                end
                CALC: begin
                    h            <= h_next;
                    compressable <= comp_next;
                end
                OUT: begin
                    if (out_ready) begin
                        min_r <= '1;
                        max_r <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_block_header_stream.sv
// Randomized and directed bench for block_header_stream against a block-level
// min/max/delta-width reference model.
module tb_block_header_stream;
    import block_header_stream_pkg::*;

    localparam int NP    = 32;
    localparam int PPB   = 4;
    localparam int NCH   = 4;
    localparam int CW    = 8;
    localparam int MDW   = 4;
    localparam int BEATS = NP / PPB;
    localparam int FLD   = 13;
    localparam int HW    = NCH * FLD;
    localparam int NBLK  = 3;

    logic clk = 1'b0;
    logic rst, in_valid, out_ready;
    logic in_ready, out_valid, compressable;
    logic [PPB-1:0][NCH-1:0][CW-1:0] in_pix;
    logic [HW-1:0] h;

    logic [7:0] blks [NBLK][BEATS][PPB][NCH];
    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    block_header_stream #(
        .NUM_PIX      (NP),
        .PIX_PER_BEAT (PPB),
        .NUM_CH       (NCH),
        .CH_W         (CW),
        .MAX_DW       (MDW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pix       (in_pix),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .h            (h),
        .compressable (compressable)
    );

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic int model_min(input int k, input int c);
        int m = 255;
        for (int b = 0; b < BEATS; b++)
            for (int p = 0; p < PPB; p++)
                if (int'(blks[k][b][p][c]) < m) m = int'(blks[k][b][p][c]);
        return m;
    endfunction

    function automatic int model_max(input int k, input int c);
        int m = 0;
        for (int b = 0; b < BEATS; b++)
            for (int p = 0; p < PPB; p++)
                if (int'(blks[k][b][p][c]) > m) m = int'(blks[k][b][p][c]);
        return m;
    endfunction

    function automatic int model_dw(input int k, input int c);
        int d = model_max(k, c) - model_min(k, c);
        int w = 0;
        while (d > 0) begin
            w++;
            d = d / 2;
        end
        return w;
    endfunction

    function automatic logic [HW-1:0] model_h(input int k);
        logic [HW-1:0] r = '0;
        logic sk;
        for (int c = 0; c < NCH; c++) begin
            sk = (model_max(k, c) == model_min(k, c));
            r[c*FLD +: FLD] = {sk, 4'(model_dw(k, c)), 8'(model_min(k, c))};
        end
        return r;
    endfunction

    function automatic logic model_comp(input int k);
        for (int c = 0; c < NCH; c++)
            if (model_dw(k, c) > MDW) return 1'b0;
        return 1'b1;
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_const(input int k, input logic [7:0] v);
        for (int b = 0; b < BEATS; b++)
            for (int p = 0; p < PPB; p++)
                for (int c = 0; c < NCH; c++)
                    blks[k][b][p][c] = v;
    endtask

    task automatic fill_chan(input int k, input int c, input int lo, input int hi);
        for (int b = 0; b < BEATS; b++)
            for (int p = 0; p < PPB; p++)
                blks[k][b][p][c] = 8'($urandom_range(hi, lo));
        blks[k][0][0][c] = 8'(lo);
        blks[k][BEATS-1][PPB-1][c] = 8'(hi);
    endtask

    task automatic fill_rand(input int k);
        int lo, hi;
        for (int c = 0; c < NCH; c++) begin
            lo = $urandom_range(0, 255);
            case ($urandom_range(0, 3))
                0: hi = lo;
                1: hi = lo + $urandom_range(1, 15);
                2: hi = lo + $urandom_range(16, 40);
                default: hi = lo + $urandom_range(0, 255);
            endcase
            if (hi > 255) hi = 255;
            fill_chan(k, c, lo, hi);
        end
    endtask

    task automatic drive_beat(input int k, input int b);
        for (int p = 0; p < PPB; p++)
            for (int c = 0; c < NCH; c++)
                in_pix[p][c] = blks[k][b][p][c];
    endtask

    // Presents all beats of block k, one per cycle; ends just after the
    // edge that accepts the last beat.
    task automatic run_block(input int k);
        for (int b = 0; b < BEATS; b++) begin
            drive_beat(k, b);
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic release_hdr();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_pix = '0;
        step(); step();
        rst = 1'b0;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b want 0", out_valid); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b want 1", in_ready); else n_pass++;
        n_total++; if (h !== '0) $display("FAIL reset_h: got %h want 0", h); else n_pass++;
        n_total++; if (compressable !== 1'b0) $display("FAIL reset_comp: got %0b want 0", compressable); else n_pass++;
    endtask

    task automatic test_constant();
        hdr_fld_t f;
        fill_const(0, 8'h40);
        run_block(0);
        n_total++; if (out_valid !== 1'b0) $display("FAIL const_calc_valid: got %0b want 0", out_valid); else n_pass++;
        n_total++; if (in_ready !== 1'b0) $display("FAIL const_calc_ready: got %0b want 0", in_ready); else n_pass++;
        step();
        n_total++; if (out_valid !== 1'b1) $display("FAIL const_out_valid: got %0b want 1", out_valid); else n_pass++;
        n_total++; if (h !== model_h(0)) $display("FAIL const_h: got %h want %h", h, model_h(0)); else n_pass++;
        n_total++; if (compressable !== 1'b1) $display("FAIL const_comp: got %0b want 1", compressable); else n_pass++;
        for (int c = 0; c < NCH; c++) begin
            f = h[c*FLD +: FLD];
            n_total++; if (f.min !== 8'h40) $display("FAIL const_min ch%0d: got %h want 40", c, f.min); else n_pass++;
            n_total++; if (f.dw !== 4'd0) $display("FAIL const_dw ch%0d: got %0d want 0", c, f.dw); else n_pass++;
            n_total++; if (f.skip !== 1'b1) $display("FAIL const_skip ch%0d: got %0b want 1", c, f.skip); else n_pass++;
        end
        release_hdr();
        n_total++; if (out_valid !== 1'b0) $display("FAIL const_release_valid: got %0b want 0", out_valid); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL const_release_ready: got %0b want 1", in_ready); else n_pass++;
    endtask

    task automatic test_span();
        hdr_fld_t f;
        for (int c = 1; c < NCH; c++) fill_chan(0, c, 8'h33 * c, 8'h33 * c);
        fill_chan(0, 0, 8'h10, 8'h1F);
        run_block(0);
        step();
        f = h[0 +: FLD];
        n_total++; if (f.min !== 8'h10) $display("FAIL span4_min: got %h want 10", f.min); else n_pass++;
        n_total++; if (f.dw !== 4'd4) $display("FAIL span4_dw: got %0d want 4", f.dw); else n_pass++;
        n_total++; if (f.skip !== 1'b0) $display("FAIL span4_skip: got %0b want 0", f.skip); else n_pass++;
        n_total++; if (compressable !== 1'b1) $display("FAIL span4_comp: got %0b want 1", compressable); else n_pass++;
        n_total++; if (h !== model_h(0)) $display("FAIL span4_h: got %h want %h", h, model_h(0)); else n_pass++;
        release_hdr();
        blks[0][3][2][0] = 8'h20;
        run_block(0);
        step();
        f = h[0 +: FLD];
        n_total++; if (f.dw !== 4'd5) $display("FAIL span5_dw: got %0d want 5", f.dw); else n_pass++;
        n_total++; if (compressable !== 1'b0) $display("FAIL span5_comp: got %0b want 0", compressable); else n_pass++;
        n_total++; if (h !== model_h(0)) $display("FAIL span5_h: got %h want %h", h, model_h(0)); else n_pass++;
        release_hdr();
    endtask

    task automatic test_full_range();
        hdr_fld_t f;
        int base;
        for (int c = 0; c < 3; c++) begin
            base = $urandom_range(0, 250);
            fill_chan(0, c, base, base + 3);
        end
        fill_chan(0, 3, 8'h00, 8'hFF);
        run_block(0);
        step();
        f = h[3*FLD +: FLD];
        n_total++; if (f.min !== 8'h00) $display("FAIL full_min: got %h want 00", f.min); else n_pass++;
        n_total++; if (f.dw !== 4'd8) $display("FAIL full_dw: got %0d want 8", f.dw); else n_pass++;
        n_total++; if (h !== model_h(0)) $display("FAIL full_h: got %h want %h", h, model_h(0)); else n_pass++;
        n_total++; if (compressable !== model_comp(0)) $display("FAIL full_comp: got %0b want %0b", compressable, model_comp(0)); else n_pass++;
        release_hdr();
    endtask

    task automatic test_backpressure();
        logic [HW-1:0] held_h;
        logic held_c;
        fill_rand(0);
        for (int b = 0; b < BEATS; b++)
            for (int p = 0; p < PPB; p++)
                for (int c = 0; c < NCH; c++)
                    blks[1][b][p][c] = 8'($urandom_range(8'h50, 8'h60));
        run_block(0);
        step();
        n_total++; if (h !== model_h(0)) $display("FAIL bp_h: got %h want %h", h, model_h(0)); else n_pass++;
        n_total++; if (compressable !== model_comp(0)) $display("FAIL bp_comp: got %0b want %0b", compressable, model_comp(0)); else n_pass++;
        held_h = h;
        held_c = compressable;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            for (int c = 0; c < NCH; c++) begin
                in_pix[0][c] = 8'h00;
                in_pix[1][c] = 8'hFF;
                in_pix[2][c] = 8'($urandom);
                in_pix[3][c] = 8'($urandom);
            end
            step();
            n_total++; if (h !== held_h) $display("FAIL bp_hold_h cyc%0d: got %h want %h", i, h, held_h); else n_pass++;
            n_total++; if (compressable !== held_c) $display("FAIL bp_hold_comp cyc%0d: got %0b want %0b", i, compressable, held_c); else n_pass++;
            n_total++; if (in_ready !== 1'b0) $display("FAIL bp_hold_ready cyc%0d: got %0b want 0", i, in_ready); else n_pass++;
            n_total++; if (out_valid !== 1'b1) $display("FAIL bp_hold_valid cyc%0d: got %0b want 1", i, out_valid); else n_pass++;
        end
        in_valid = 1'b0;
        release_hdr();
        n_total++; if (out_valid !== 1'b0) $display("FAIL bp_release_valid: got %0b want 0", out_valid); else n_pass++;
        run_block(1);
        step();
        n_total++; if (h !== model_h(1)) $display("FAIL bp_fresh_h: got %h want %h", h, model_h(1)); else n_pass++;
        n_total++; if (compressable !== model_comp(1)) $display("FAIL bp_fresh_comp: got %0b want %0b", compressable, model_comp(1)); else n_pass++;
        release_hdr();
    endtask

    task automatic test_reset_mid();
        hdr_fld_t f;
        for (int b = 0; b < BEATS; b++)
            for (int p = 0; p < PPB; p++)
                for (int c = 0; c < NCH; c++)
                    blks[0][b][p][c] = p[0] ? 8'hFF : 8'h00;
        fill_const(1, 8'h80);
        for (int b = 0; b < 3; b++) begin
            drive_beat(0, b);
            in_valid = 1'b1;
            step();
        end
        drive_beat(0, 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        n_total++; if (out_valid !== 1'b0) $display("FAIL rmid_valid: got %0b want 0", out_valid); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL rmid_ready: got %0b want 1", in_ready); else n_pass++;
        n_total++; if (h !== '0) $display("FAIL rmid_h: got %h want 0", h); else n_pass++;
        n_total++; if (compressable !== 1'b0) $display("FAIL rmid_comp: got %0b want 0", compressable); else n_pass++;
        run_block(1);
        step();
        n_total++; if (out_valid !== 1'b1) $display("FAIL rmid_after_valid: got %0b want 1", out_valid); else n_pass++;
        for (int c = 0; c < NCH; c++) begin
            f = h[c*FLD +: FLD];
            n_total++; if (f.min !== 8'h80) $display("FAIL rmid_min ch%0d: got %h want 80", c, f.min); else n_pass++;
            n_total++; if (f.dw !== 4'd0) $display("FAIL rmid_dw ch%0d: got %0d want 0", c, f.dw); else n_pass++;
            n_total++; if (f.skip !== 1'b1) $display("FAIL rmid_skip ch%0d: got %0b want 1", c, f.skip); else n_pass++;
        end
        // Reset while a header is being offered.
        rst = 1'b1;
        out_ready = 1'b1;
        step();
        rst = 1'b0;
        out_ready = 1'b0;
        n_total++; if (out_valid !== 1'b0) $display("FAIL rout_valid: got %0b want 0", out_valid); else n_pass++;
        n_total++; if (h !== '0) $display("FAIL rout_h: got %h want 0", h); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL rout_ready: got %0b want 1", in_ready); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int gi = 0, cnt = 0, hdr = 0, cyc = 0, last = 0;
        logic xfer;
        for (int k = 0; k < NBLK; k++) fill_rand(k);
        out_ready = 1'b1;
        while (hdr < NBLK && cyc < 300) begin
            if (gi < NBLK * BEATS) begin
                drive_beat(gi / BEATS, gi % BEATS);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            xfer = in_valid && in_ready;
            step();
            cyc++;
            if (xfer) begin
                gi++;
                cnt++;
                last = cyc;
            end
            if (out_valid) begin
                n_total++; if (cnt !== BEATS) $display("FAIL b2b_beats hdr%0d: got %0d want %0d", hdr, cnt, BEATS); else n_pass++;
                n_total++; if (cyc - last !== 1) $display("FAIL b2b_latency hdr%0d: got %0d want 1", hdr, cyc - last); else n_pass++;
                n_total++; if (h !== model_h(hdr)) $display("FAIL b2b_h hdr%0d: got %h want %h", hdr, h, model_h(hdr)); else n_pass++;
                n_total++; if (compressable !== model_comp(hdr)) $display("FAIL b2b_comp hdr%0d: got %0b want %0b", hdr, compressable, model_comp(hdr)); else n_pass++;
                hdr++;
                cnt = 0;
            end
        end
        n_total++; if (hdr !== NBLK) $display("FAIL b2b_timeout: got %0d headers want %0d", hdr, NBLK); else n_pass++;
        in_valid = 1'b0;
        out_ready = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_constant();
        test_span();
        test_full_range();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
